// File: rtl/sha3_scan_sequencer.sv
// sha3_scan_sequencer: splits one mining job's nonce range into scanner slices,
// patches the nonce word per slice and reports a single result record per job.
module sha3_scan_sequencer #(
  parameter int PROPER = 1,
  parameter int NONCE_WORD = 19,
  parameter int GUARD_CYCLES = 2,
  localparam int WORDS = PROPER ? 20 : 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [WORDS-1:0][31:0] job_blobby,
  input  logic [63:0]            job_threshold,
  input  logic [31:0]            job_nonce_first,
  input  logic [31:0]            job_nonce_last,
  input  logic                   abort,
  output logic                   sc_start,
  output logic [63:0]            sc_threshold,
  output logic [WORDS-1:0][31:0] sc_blobby,
  input  logic                   sc_ready,
  input  logic                   sc_found,
  input  logic [31:0]            sc_nonce,
  input  logic [24:0][63:0]      sc_hash,
  input  logic [31:0]            sc_scan_count,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_kind,
  output logic [31:0]            res_nonce,
  output logic [24:0][63:0]      res_hash,
  output logic [31:0]            slices,
  output logic                   busy
);
  localparam int GW = $clog2(GUARD_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, REPORT} state_t;
  state_t state, state_n;
  logic [WORDS-1:0][31:0] blob;
  logic [31:0] base, last;
  logic abort_flag;
  logic [GW-1:0] gcnt;
  logic [32:0] next;
  logic rep, adv, stop;
  logic [1:0] rep_kind;
  logic [31:0] rep_nonce;
  assign next = {1'b0, base} + {1'b0, sc_scan_count};
  assign stop = abort | abort_flag;
  assign job_ready = state == IDLE;
  assign res_valid = state == REPORT;
  assign busy = state != IDLE;
  always_comb begin
    sc_blobby = blob;
    sc_blobby[NONCE_WORD] = base;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    sc_start = 1'b0;
    rep = 1'b0;
    adv = 1'b0;
    rep_kind = 2'd1;
    rep_nonce = base;
    case (state)
      IDLE: if (job_valid) begin
        rep = job_nonce_first > job_nonce_last;
        rep_nonce = job_nonce_first;
        state_n = rep ? REPORT : ISSUE;
      end
      ISSUE: begin
        rep = stop;
        rep_kind = 2'd2;
        sc_start = !stop && sc_ready;
        state_n = stop ? REPORT : sc_ready ? GUARD : ISSUE;
      end
      GUARD: state_n = gcnt <= GW'(1) ? WAIT : GUARD;
      // a carry out of the 32-bit base also lands above last, so one compare covers wrap
      WAIT: if (sc_ready) begin
        rep = sc_found | stop | (next > {1'b0, last});
        rep_kind = sc_found ? 2'd0 : stop ? 2'd2 : 2'd1;
        rep_nonce = sc_found ? sc_nonce : base;
        adv = !rep;
        state_n = rep ? REPORT : ISSUE;
      end
      REPORT: state_n = res_ready ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blob <= '0;
      sc_threshold <= '0;
      base <= '0;
      last <= '0;
      slices <= '0;
      abort_flag <= 1'b0;
      gcnt <= '0;
      res_kind <= '0;
      res_nonce <= '0;
      res_hash <= '0;
    end else begin
      if (state == IDLE && job_valid) begin
        blob <= job_blobby;
        sc_threshold <= job_threshold;
        base <= job_nonce_first;
        last <= job_nonce_last;
        slices <= '0;
        abort_flag <= 1'b0;
      end else if (abort && busy && !res_valid) abort_flag <= 1'b1;
      if (sc_start) begin
        slices <= slices + {31'd0, ~&slices};
        gcnt <= GW'(GUARD_CYCLES);
      end else if (state == GUARD) gcnt <= gcnt - GW'(1);
      if (adv) base <= next[31:0];
      if (rep) begin
        res_kind <= rep_kind;
        res_nonce <= rep_nonce;
        res_hash <= rep_kind == 2'd0 ? sc_hash : '0;
      end
    end
  end
endmodule

// File: tb/tb_sha3_scan_sequencer.sv
// tb_sha3_scan_sequencer: directed job scenarios with hand-computed slice bases and results.
module tb_sha3_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic job_ready;
  logic [19:0][31:0] job_blobby;
  logic [63:0] job_threshold = 64'h0000_0FFF_FFFF_FFFF;
  logic [31:0] job_nonce_first = '0;
  logic [31:0] job_nonce_last = '0;
  logic abort = 1'b0;
  logic sc_start;
  logic [63:0] sc_threshold;
  logic [19:0][31:0] sc_blobby;
  logic sc_ready = 1'b1;
  logic sc_found = 1'b0;
  logic [31:0] sc_nonce = '0;
  logic [24:0][63:0] sc_hash;
  logic [31:0] sc_scan_count = 32'd16;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [1:0] res_kind;
  logic [31:0] res_nonce;
  logic [24:0][63:0] res_hash;
  logic [31:0] slices;
  logic busy;
  int errors = 0;
  int checks = 0;
  int nstarts = 0;
  int s0;

  sha3_scan_sequencer dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_blobby(job_blobby), .job_threshold(job_threshold),
    .job_nonce_first(job_nonce_first), .job_nonce_last(job_nonce_last),
    .abort(abort), .sc_start(sc_start), .sc_threshold(sc_threshold),
    .sc_blobby(sc_blobby), .sc_ready(sc_ready), .sc_found(sc_found),
    .sc_nonce(sc_nonce), .sc_hash(sc_hash), .sc_scan_count(sc_scan_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_kind(res_kind),
    .res_nonce(res_nonce), .res_hash(res_hash), .slices(slices), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (sc_start) nstarts++;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_job(input logic [31:0] first, input logic [31:0] last);
    chk("job_ready_idle", job_ready, 1);
    job_nonce_first = first;
    job_nonce_last = last;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
  endtask

  task automatic slice(input logic [31:0] b, input logic f, input logic [31:0] n, input logic ab);
    for (int i = 0; i < 20 && sc_start !== 1'b1; i++) step();
    chk("sc_start", sc_start, 1);
    chk("slice_base", sc_blobby[19], b);
    step();
    sc_ready = 1'b0;
    abort = ab;
    step();
    abort = 1'b0;
    step();
    sc_ready = 1'b1;
    sc_found = f;
    sc_nonce = n;
    step();
    sc_found = 1'b0;
  endtask

  task automatic take();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("job_ready_after", job_ready, 1);
    chk("res_valid_after", res_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) job_blobby[i] = 32'hB000_0000 + i;
    for (int i = 0; i < 25; i++) sc_hash[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 3);
    step();
    step();
    rst = 1'b0;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sc_start", sc_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_kind", res_kind, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_hash0", res_hash[0], 0);
    chk("rst_slices", slices, 0);
    chk("rst_thr", sc_threshold, 0);
    chk("rst_blob", sc_blobby[5], 0);

    // 0..63 by 16, never found
    s0 = nstarts;
    send_job(0, 63);
    chk("latency1", sc_start, 1);
    chk("thr_latched", sc_threshold, 64'h0000_0FFF_FFFF_FFFF);
    chk("blob_word3", sc_blobby[3], 32'hB000_0003);
    slice(0, 0, 0, 0);
    slice(16, 0, 0, 0);
    slice(32, 0, 0, 0);
    slice(48, 0, 0, 0);
    chk("exh_valid", res_valid, 1);
    chk("exh_kind", res_kind, 1);
    chk("exh_nonce", res_nonce, 48);
    chk("exh_slices", slices, 4);
    chk("exh_hash", res_hash[7], 0);
    chk("exh_starts", nstarts - s0, 4);
    take();

    // found at nonce 37 in the third slice; result held while res_ready low
    s0 = nstarts;
    send_job(0, 63);
    slice(0, 0, 0, 0);
    slice(16, 0, 0, 0);
    slice(32, 1, 37, 0);
    chk("fnd_kind", res_kind, 0);
    chk("fnd_nonce", res_nonce, 37);
    chk("fnd_slices", slices, 3);
    for (int i = 0; i < 25; i++) chk("fnd_hash", res_hash[i], 64'hA5A5_0000_0000_0000 + 64'(i * 3));
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_nonce", res_nonce, 37);
      chk("hold_job_ready", job_ready, 0);
      step();
    end
    chk("hold_starts", nstarts - s0, 3);
    take();

    // top of the nonce space: one slice, no wrap
    s0 = nstarts;
    send_job(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    slice(32'hFFFF_FFF0, 0, 0, 0);
    chk("top_kind", res_kind, 1);
    chk("top_nonce", res_nonce, 32'hFFFF_FFF0);
    chk("top_slices", slices, 1);
    chk("top_starts", nstarts - s0, 1);
    take();

    // abort during guard of slice 2
    send_job(0, 63);
    slice(0, 0, 0, 0);
    slice(16, 0, 0, 1);
    chk("abt_kind", res_kind, 2);
    chk("abt_nonce", res_nonce, 16);
    chk("abt_slices", slices, 2);
    take();

    // abort during guard of slice 2, but that slice hits
    send_job(0, 63);
    slice(0, 0, 0, 0);
    slice(16, 1, 20, 1);
    chk("abth_kind", res_kind, 0);
    chk("abth_nonce", res_nonce, 20);
    take();

    // abort while waiting in ISSUE: nothing issued
    s0 = nstarts;
    sc_ready = 1'b0;
    send_job(100, 200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    sc_ready = 1'b1;
    chk("abti_valid", res_valid, 1);
    chk("abti_kind", res_kind, 2);
    chk("abti_nonce", res_nonce, 100);
    chk("abti_slices", slices, 0);
    chk("abti_starts", nstarts - s0, 0);
    take();

    // reset while in WAIT
    send_job(0, 63);
    slice(0, 0, 0, 0);
    step();
    sc_ready = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sc_ready = 1'b1;
    chk("wrst_job_ready", job_ready, 1);
    chk("wrst_busy", busy, 0);
    chk("wrst_slices", slices, 0);
    chk("wrst_res_nonce", res_nonce, 0);
    chk("wrst_thr", sc_threshold, 0);
    chk("wrst_blob", sc_blobby[19], 0);
    s0 = nstarts;
    send_job(0, 15);
    slice(0, 0, 0, 0);
    chk("post_kind", res_kind, 1);
    chk("post_nonce", res_nonce, 0);
    chk("post_slices", slices, 1);
    take();

    // empty range
    s0 = nstarts;
    send_job(5, 4);
    chk("empty_valid", res_valid, 1);
    chk("empty_kind", res_kind, 1);
    chk("empty_nonce", res_nonce, 5);
    chk("empty_slices", slices, 0);
    chk("empty_starts", nstarts - s0, 0);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
